// File: rtl/pipeif.sv
// ----------------------------------------------------------------------------
// pipeif -- instruction fetch stage with a one-entry hold buffer and a
// one-instruction architectural delay slot.
//
// Handshake: imem_req is high only while a fetch is outstanding; imem_addr
// (== pc) is held stable until the cycle imem_ack is high, and imem_rdata is
// consumed in that same cycle. ID consumes IF/ID contents on any cycle it
// drives nostall=1.
//
// Ports
//   clk, clrn              clock, asynchronous active-low reset
//   pcsource               next-PC select from ID (00 pc+4, 01 bpc, 10 da, 11 jpc)
//   bpc, da, jpc           branch / register / jump targets from ID
//   nostall                ID accepts new IF/ID contents this cycle
//   imem_req, imem_addr    fetch request and address
//   imem_ack, imem_rdata   fetch completion and returned word
//   dpc4, inst, dvalid     IF/ID register (dvalid=0 marks an injected bubble)
//   pc                     current fetch PC
//   fetch_err              sticky misaligned-target flag (PIPEIF_ALIGN_CHK_EN only)
//   state_dbg              current FSM state, for observation
//
// Build option: define PIPEIF_ALIGN_CHK_EN to trap misaligned targets (HALT
// state plus fetch_err); otherwise target bits [1:0] are forced to zero.
// ----------------------------------------------------------------------------
module pipeif (
    input  logic        clk,
    input  logic        clrn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    input  logic        nostall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        dvalid,
    output logic [31:0] pc,
`ifdef PIPEIF_ALIGN_CHK_EN
    output logic        fetch_err,
`endif
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dpc4_q, dpc4_d;
    logic [31:0] inst_q, inst_d;
    logic        dvalid_q, dvalid_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        redir_vld_q, redir_vld_d;
    logic        imem_req_q, imem_req_d;
`ifdef PIPEIF_ALIGN_CHK_EN
    logic        fetch_err_q, fetch_err_d;
`endif

    logic [31:0] pc4;
    logic [31:0] sel_tgt;
    logic [31:0] tgt_ld;
    logic [31:0] npc;
    logic        load_pc;

    always_comb begin
        pc4 = pc_q + 32'd4;
        case (pcsource)
            2'b01:   sel_tgt = bpc;
            2'b10:   sel_tgt = da;
            2'b11:   sel_tgt = jpc;
            default: sel_tgt = pc4;
        endcase
`ifdef PIPEIF_ALIGN_CHK_EN
        // Keep the raw value so a misaligned target is caught when it reaches pc.
        tgt_ld = sel_tgt;
`else
        tgt_ld = sel_tgt & 32'hFFFF_FFFC;
`endif
        // A redirect captured during a stalled fetch wins over ID's current select.
        npc = redir_vld_q ? redir_pc_q : tgt_ld;

        state_d     = state_q;
        pc_d        = pc_q;
        dpc4_d      = dpc4_q;
        inst_d      = inst_q;
        dvalid_d    = dvalid_q;
        hold_pc4_d  = hold_pc4_q;
        hold_inst_d = hold_inst_q;
        redir_pc_d  = redir_pc_q;
        redir_vld_d = redir_vld_q;
        load_pc     = 1'b0;
`ifdef PIPEIF_ALIGN_CHK_EN
        fetch_err_d = fetch_err_q;
`endif

        case (state_q)
            ST_RUN: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (nostall) begin
                        dpc4_d   = pc4;
                        inst_d   = imem_rdata;
                        dvalid_d = 1'b1;
                        load_pc  = 1'b1;
                    end else begin
                        hold_pc4_d  = pc4;
                        hold_inst_d = imem_rdata;
                        state_d     = ST_HOLD;
                    end
                end else if (nostall) begin
                    // ID advances into a bubble; remember any redirect it is
                    // issuing since the next ID instruction will be that bubble.
                    inst_d   = 32'h0;
                    dvalid_d = 1'b0;
                    if (pcsource != 2'b00) begin
                        redir_pc_d  = tgt_ld;
                        redir_vld_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (nostall) begin
                    dpc4_d   = hold_pc4_q;
                    inst_d   = hold_inst_q;
                    dvalid_d = 1'b1;
                    load_pc  = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            default: begin
                // HALT: no fetching, only bubbles toward ID.
                if (nostall) begin
                    inst_d   = 32'h0;
                    dvalid_d = 1'b0;
                end
            end
        endcase

        if (load_pc) begin
            pc_d        = npc;
            redir_vld_d = 1'b0;
`ifdef PIPEIF_ALIGN_CHK_EN
            if (npc[1:0] != 2'b00) begin
                fetch_err_d = 1'b1;
                state_d     = ST_HALT;
            end
`endif
        end

        imem_req_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= ST_RUN;
            pc_q        <= 32'h0;
            dpc4_q      <= 32'h0;
            inst_q      <= 32'h0;
            dvalid_q    <= 1'b0;
            hold_pc4_q  <= 32'h0;
            hold_inst_q <= 32'h0;
            redir_pc_q  <= 32'h0;
            redir_vld_q <= 1'b0;
            imem_req_q  <= 1'b0;
`ifdef PIPEIF_ALIGN_CHK_EN
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            dpc4_q      <= dpc4_d;
            inst_q      <= inst_d;
            dvalid_q    <= dvalid_d;
            hold_pc4_q  <= hold_pc4_d;
            hold_inst_q <= hold_inst_d;
            redir_pc_q  <= redir_pc_d;
            redir_vld_q <= redir_vld_d;
            imem_req_q  <= imem_req_d;
`ifdef PIPEIF_ALIGN_CHK_EN
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign dpc4      = dpc4_q;
    assign inst      = inst_q;
    assign dvalid    = dvalid_q;
    assign state_dbg = state_q;
`ifdef PIPEIF_ALIGN_CHK_EN
    assign fetch_err = fetch_err_q;
`endif

endmodule

// File: doc/pipeif.md
PIPEIF -- requirements
Module: pipeif

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: clrn  input  1  reset; asynchronous, active-low.
REQ-003 SHALL: pcsource  input  2  next-PC select from ID: 00 pc+4, 01 bpc, 10 da, 11 jpc.
REQ-004 SHALL: bpc / da / jpc  input  32 each  branch target / register (jr) target / jump target from ID.
REQ-005 SHALL: nostall  input  1  ID accepts new IF/ID contents this cycle when 1.
REQ-006 SHALL: imem_req  output  1  fetch request to instruction memory.
REQ-007 SHALL: imem_addr  output  32  fetch address, equal to pc.
REQ-008 SHALL: imem_ack / imem_rdata  input  1 / 32  fetch complete; rdata valid in the same cycle.
REQ-009 SHALL: dpc4 / inst  output  32 each  IF/ID register: fetched pc+4 and instruction word.
REQ-010 SHALL: dvalid  output  1  inst holds a real fetched instruction (0 = injected NOP bubble).
REQ-011 SHALL: pc  output  32  current fetch PC (debug).

Function
REQ-012 SHALL: FSM states RUN, FETCH, HOLD (HALT only with the macro in REQ-030).
- RUN is the first cycle after reset.
- RUN always moves to FETCH.
REQ-013 SHALL: imem_req=1 only in FETCH.
- imem_addr stays stable until imem_ack.
- pc never changes while a request is outstanding.
REQ-014 SHALL: fetch completion is FETCH with imem_ack=1, or the HOLD state.
REQ-015 SHALL: FETCH, imem_ack=1, nostall=1:
- IF/ID <= {pc+4, imem_rdata}, dvalid <= 1.
- pc <= npc.
- stay in FETCH.
REQ-016 SHALL: FETCH, imem_ack=1, nostall=0:
- imem_rdata and pc+4 captured into a one-entry hold buffer.
- IF/ID unchanged.
- go to HOLD; pc unchanged.
REQ-017 SHALL: HOLD, nostall=1:
- IF/ID <= hold buffer, dvalid <= 1.
- pc <= npc.
- go to FETCH.
REQ-018 SHALL: HOLD, nostall=0: everything unchanged.
REQ-019 SHALL: FETCH, imem_ack=0, nostall=1:
- IF/ID <= {dpc4 unchanged, 32'h0}, dvalid <= 0.
- pc unchanged.
REQ-020 SHALL: FETCH, imem_ack=0, nostall=0: IF/ID unchanged.
REQ-021 SHALL: npc = redirect register value if redir_vld=1; otherwise the pcsource mux of {pc+4, bpc, da, jpc}.
- pc+4 wraps modulo 2^32.
REQ-022 SHALL: one architectural delay slot.
- A redirect seen while ID advances (nostall=1) applies to the fetch after the one completing that cycle.
REQ-023 SHALL: if nostall=1, pcsource!=00 and fetch is not complete:
- redir_pc <= selected target, redir_vld <= 1.
- The next completion loads pc from redir_pc and clears redir_vld.
REQ-024 SHALL: a completion with nostall=1 and redir_vld=1 uses redir_pc and ignores pcsource.
- A bubble in ID gives pcsource=00, so there is no conflict.

Reset
REQ-025 SHALL: while clrn=0, state <= RUN immediately, including when a fetch is outstanding.
REQ-026 SHALL: reset values:
- pc=32'h0000_0000, dpc4=0, inst=0, dvalid=0, imem_req=0.
- redir_vld=0, hold buffer=0.
REQ-027 SHALL: an imem_ack arriving in the cycle reset is released is ignored; the first request issues from FETCH at addr 0.

Configuration
REQ-028 SHALL: macro PIPEIF_ALIGN_CHK_EN controls target alignment checking.
REQ-029 SHALL: without PIPEIF_ALIGN_CHK_EN:
- npc[1:0] forced to 2'b00 before loading pc or redir_pc.
- No fetch_err port.
REQ-030 SHALL: with PIPEIF_ALIGN_CHK_EN:
- Adds output fetch_err (1 bit).
- If a loaded npc has [1:0]!=00, pc keeps the bad value, fetch_err <= 1 (sticky), FSM enters HALT.
- HALT: imem_req=0, bubbles injected whenever nostall=1; exit only by reset.

Verification
REQ-031 SHALL: ack every cycle, nostall=1 from reset -> imem_addr 0,4,8,C; inst tracks rdata one cycle later, dvalid=1.
REQ-032 SHALL: beq in ID, pcsource=01, bpc=32'h40, ack immediate -> delay slot at 8 fetched, next imem_addr=32'h40.
REQ-033 SHALL: pcsource=11, jpc=32'h100, imem_ack delayed 3 cycles, nostall=1 -> bubbles with dvalid=0, redir_vld set; after the delay-slot ack, imem_addr=32'h100.
REQ-034 SHALL: ack while nostall=0 for 2 cycles -> HOLD, imem_req=0; when nostall returns to 1, the held word appears on inst and fetch resumes at pc+4.
REQ-035 SHALL: clrn pulsed low during an outstanding request at addr 32'h20 -> all outputs return to reset values; the next request is at addr 0.
REQ-036 SHALL: with the macro, pcsource=10, da=32'h103 -> fetch_err=1, imem_req stays 0; without the macro, imem_addr=32'h100.
